// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute stage.
//   - OP_* : 4-bit op select codes driven by the ALU control decoder
//   - state_t : execute-stage FSM states
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_NOR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_DIV = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1001;
    localparam logic [3:0] OP_GEZ = 4'b1011;
    localparam logic [3:0] OP_NOP = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned multiply / divide engine, one bit per step.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture operands a/b and mode is_div, clear counter
//   step      : perform one iteration
//   lo_next   : low word after the current step (product low / quotient)
//   hi_next   : high word after the current step (product high / remainder)
//   last      : the current step is the final (WIDTH-th) one
// Multiply uses shift-add on {hi,lo} with lo initially holding the multiplier.
// Divide is restoring: lo initially holds the dividend and is shifted into
// the partial remainder in hi while quotient bits are shifted into lo.
module mul_div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next,
    output logic             last
);

    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic             div_mode_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then
        // shift the (WIDTH+1)-bit sum and the multiplier right together.
        sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        // Divide: bring in the next dividend bit and trial-subtract.
        shifted = {hi_reg, lo_reg[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd_reg});
        // When ge holds the difference is below the divisor, so the low
        // WIDTH bits are exact.
        diff    = shifted[WIDTH-1:0] - opnd_reg;
        if (div_mode_reg) begin
            hi_next = ge ? diff : shifted[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], ge};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo_reg[WIDTH-1:1]};
        end
        last = (cnt_reg == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_reg       <= '0;
            hi_reg       <= '0;
            opnd_reg     <= '0;
            div_mode_reg <= 1'b0;
            cnt_reg      <= '0;
        end else if (load) begin
            lo_reg       <= a;
            hi_reg       <= '0;
            opnd_reg     <= b;
            div_mode_reg <= is_div;
            cnt_reg      <= '0;
        end else if (step) begin
            lo_reg       <= lo_next;
            hi_reg       <= hi_next;
            cnt_reg      <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu_exec.sv
// Execute stage behind the ALU control decoder.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, accepted when not busy (including the DONE cycle)
//   ops, a, b    : op select and operands, sampled on accept
//   result       : primary result, held until the next completion
//   result_hi    : mul high word / div remainder / else 0
//   zero         : result == 0
//   busy         : multi-cycle op in progress (start ignored)
//   done         : one-cycle pulse, outputs valid
//   div_by_zero  : divide with b == 0
//   bad_op       : unlisted op code
// Single-cycle ops complete in the cycle after accept; MUL/DIV spend WIDTH
// cycles in RUN and complete in the following cycle.
module seq_alu_exec
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ops,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             bad_op
);

    state_t state_reg;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] alu_hi;
    logic             alu_dbz;
    logic             alu_bad;
    logic             alu_iter;
    logic             accept;
    logic             eng_load;
    logic             eng_step;
    logic [WIDTH-1:0] eng_lo;
    logic [WIDTH-1:0] eng_hi;
    logic             eng_last;

    // Single-cycle datapath; MUL and non-zero DIV are handed to the engine.
    always_comb begin
        alu_res  = '0;
        alu_hi   = '0;
        alu_dbz  = 1'b0;
        alu_bad  = 1'b0;
        alu_iter = 1'b0;
        case (ops)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_ADD: alu_res = a + b;
            OP_NOR: alu_res = ~(a | b);
            OP_SUB: alu_res = a - b;
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_GEZ: alu_res = {{(WIDTH-1){1'b0}}, ~a[WIDTH-1]};
            OP_NOP: alu_res = '0;
            OP_MUL: alu_iter = 1'b1;
            OP_DIV: begin
                if (b == '0) begin
                    alu_res = '1;
                    alu_hi  = a;
                    alu_dbz = 1'b1;
                end else begin
                    alu_iter = 1'b1;
                end
            end
            default: alu_bad = 1'b1;
        endcase
    end

    assign accept   = start && (state_reg != RUN);
    assign eng_load = accept && alu_iter;
    assign eng_step = (state_reg == RUN);

    mul_div_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (eng_load),
        .is_div  (ops == OP_DIV),
        .a       (a),
        .b       (b),
        .step    (eng_step),
        .lo_next (eng_lo),
        .hi_next (eng_hi),
        .last    (eng_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            bad_op      <= 1'b0;
        end else begin
            case (state_reg)
                // DONE behaves like IDLE for acceptance so requests can
                // issue back-to-back.
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state_reg <= IDLE;
                    if (start) begin
                        if (alu_iter) begin
                            state_reg <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            state_reg   <= DONE;
                            done        <= 1'b1;
                            result      <= alu_res;
                            result_hi   <= alu_hi;
                            zero        <= (alu_res == '0);
                            div_by_zero <= alu_dbz;
                            bad_op      <= alu_bad;
                        end
                    end
                end
                RUN: begin
                    // Capture the engine's post-step value on the final step.
                    if (eng_last) begin
                        state_reg   <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        result      <= eng_lo;
                        result_hi   <= eng_hi;
                        zero        <= (eng_lo == '0);
                        div_by_zero <= 1'b0;
                        bad_op      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Scoreboard bench for seq_alu_exec (WIDTH=32): the driver pushes expected
// responses computed from plain arithmetic; a monitor checks every cycle.
module tb_seq_alu_exec;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    ops;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic          bad_op;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        bit           dbz;
        bit           bad;
        bit           multi;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    seq_alu_exec #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ops         (ops),
        .a           (a),
        .b           (b),
        .result      (result),
        .result_hi   (result_hi),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .bad_op      (bad_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference behaviour straight from the op table.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [63:0] p;
        e.res = '0; e.hi = '0; e.dbz = 0; e.bad = 0; e.multi = 0; e.done_cyc = 0;
        case (op)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010: e.res = x + y;
            4'b0100: e.res = ~(x | y);
            4'b0110: e.res = x - y;
            4'b0101: begin
                p = 64'(x) * 64'(y);
                e.res = p[31:0]; e.hi = p[63:32]; e.multi = 1;
            end
            4'b1000: begin
                if (y == 0) begin
                    e.res = '1; e.hi = x; e.dbz = 1;
                end else begin
                    e.res = x / y; e.hi = x % y; e.multi = 1;
                end
            end
            4'b1001: e.res = ($signed(x) < $signed(y)) ? 1 : 0;
            4'b1011: e.res = ($signed(x) >= 0) ? 1 : 0;
            4'b1101: e.res = '0;
            default: e.bad = 1;
        endcase
        return e;
    endfunction

    task automatic set_held_reset();
        held.res = '0; held.hi = '0; held.dbz = 0; held.bad = 0;
        held.multi = 0; held.done_cyc = 0;
    endtask

    // Called at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        start = 1'b1; ops = op; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        ops = 4'($urandom); a = $urandom; b = $urandom;
        e = model(op, x, y);
        e.done_cyc = cyc + (e.multi ? W : 0);
        q.push_back(e);
        $display("issue op=%b a=0x%08h b=0x%08h exp_res=0x%08h exp_hi=0x%08h done@%0d",
                 op, x, y, e.res, e.hi, e.done_cyc);
    endtask

    // Returns at the negedge of the done cycle. With poke set, ADD requests
    // are thrown at the DUT while it is busy; they must be ignored.
    task automatic wait_done(input bit poke);
        bit got = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                got = 1;
                break;
            end
            if (poke) begin
                start = 1'b1; ops = 4'b0010; a = $urandom; b = $urandom;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    // Monitor: done/busy timing plus held outputs every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_done;
            bit exp_busy;
            exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
            exp_busy = (q.size() > 0) && q[0].multi && (cyc < q[0].done_cyc);
            chk("done", 64'(done), 64'(exp_done));
            chk("busy", 64'(busy), 64'(exp_busy));
            if (exp_done) held = q.pop_front();
            chk("result", 64'(result), 64'(held.res));
            chk("result_hi", 64'(result_hi), 64'(held.hi));
            chk("zero", 64'(zero), 64'(held.res == 0));
            chk("div_by_zero", 64'(div_by_zero), 64'(held.dbz));
            chk("bad_op", 64'(bad_op), 64'(held.bad));
        end
    end

    logic [3:0] legal_ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                                   4'b0110, 4'b1000, 4'b1001, 4'b1011, 4'b1101};

    initial begin
        rst = 1'b1; start = 1'b0; ops = '0; a = '0; b = '0;
        set_held_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);

        // Directed cases
        issue(4'b0010, 32'hFFFF_FFFF, 32'h1);       wait_done(0);
        repeat (2) @(negedge clk);
        issue(4'b1001, 32'hFFFF_FFFE, 32'h1);       wait_done(0);
        @(negedge clk);
        issue(4'b0101, 32'h0001_0000, 32'h0001_0000); wait_done(1);
        issue(4'b1000, 32'd100, 32'd7);             wait_done(0);
        issue(4'b1000, 32'h1234_5678, 32'h0);       wait_done(0);
        issue(4'b1111, 32'hDEAD_BEEF, 32'h5);       wait_done(0);
        @(negedge clk);

        // Reset in the 10th cycle of a MUL: abort, no done.
        issue(4'b0101, 32'hABCD_1234, 32'h9876_5432);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        set_held_reset();
        repeat (3) @(negedge clk);

        // start and rst together: request dropped.
        rst = 1'b1; start = 1'b1; ops = 4'b0010; a = 32'd5; b = 32'd6;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        q.delete();
        set_held_reset();
        repeat (3) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [3:0]   op;
            logic [W-1:0] x;
            logic [W-1:0] y;
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 9)];
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = '0;
                1: y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            issue(op, x, y);
            wait_done($urandom_range(0, 1) == 1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
